serial_chunk_adder: RTL and testbench
=====================================

Name: serial_chunk_adder

Overview:
- Parametrised, multi-cycle successor to the 1-bit full-adder cell.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, holding the carry in a register between chunks.
- Raises a one-cycle done pulse with sum, carry-out and signed overflow.
- Serves as a low-area ALU adder option for the processor datapath, trading latency for logic.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH. NCH = WIDTH/CHUNK is the number of RUN cycles.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = A+B+Cin; 1 = A−B (A + ~B + 1, Cin ignored).
- A  input  WIDTH  operand A; latched at accept.
- B  input  WIDTH  operand B; latched at accept.
- Cin  input  1  carry-in for add mode; latched at accept.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse; result valid.
- S  output  WIDTH  sum/difference; holds until next accept or reset.
- Cout  output  1  carry out of the MSB (sub: 1 = no borrow).
- Ofl  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, chunk counter=0, carry reg=0.
  - S=0, Cout=0, Ofl=0, busy=0, done=0.
  - Takes effect immediately, including mid-operation; the operation in flight is aborted, never completed.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On a rising edge with start=1: latch A into opA and (sub ? ~B : B) into opB.
  - Set carry = sub ? 1 : Cin, counter=0, clear S, go to RUN.
  - start=0: remain in IDLE; outputs hold.
- RUN, per edge with k = counter:
  - {c, s} = opA[k*CHUNK +: CHUNK] + opB[k*CHUNK +: CHUNK] + carry.
  - Write s to S[k*CHUNK +: CHUNK]; carry ← c.
  - On the last chunk (k=NCH−1):
    - capture Ofl from the carry into bit WIDTH−1 (computed inside the chunk) XOR c.
    - Cout ← c; go to DONE.
  - Otherwise counter ← k+1.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE unconditionally.
- Latency: with start accepted at edge t, done is high between edges t+NCH and t+NCH+1. Back-to-back throughput is one operation per NCH+2 cycles.
- start while busy (RUN or DONE) is ignored. A/B/Cin/sub changes after accept have no effect.
- S, Cout and Ofl are stable from done until the next accept. Partial S bits during RUN are not valid.
- CHUNK=WIDTH degenerates to a single RUN cycle. CHUNK=1 is a pure bit-serial adder.
- Arithmetic is modulo 2^WIDTH; no saturation.

Test Plan:
- WIDTH=16, CHUNK=4; A=0x1234, B=0x0FF1, Cin=0, add -> S=0x2225, Cout=0, Ofl=0; done high exactly between edges t+4 and t+5; busy high for 5 cycles.
- Full ripple across chunks: A=0xFFFF, B=0x0001, add -> S=0x0000, Cout=1, Ofl=0. Also A=0x00FF, B=0x0000, Cin=1 -> S=0x0100, Cout=0.
- Signed overflow:
  - A=0x7FFF, B=0x0001, add -> S=0x8000, Cout=0, Ofl=1.
  - A=0x8000, B=0x0001, sub -> S=0x7FFF, Cout=1, Ofl=1.
  - A=0x0005, B=0x0007, sub, Cin=1 (ignored) -> S=0xFFFE, Cout=0, Ofl=0.
- Busy handling:
  - start re-asserted in RUN and DONE with A=0xAAAA -> ignored; first result delivered unchanged.
  - start held high continuously -> new accept on the IDLE cycle after done; done pulses are NCH+2 cycles apart.
- Reset mid-operation: rst_n low asynchronously during the 2nd RUN cycle -> busy, done, S, Cout and Ofl go to 0 without waiting for a clock edge. After release, 0x0001+0x0002 -> S=0x0003 with normal latency.
- Parameter sweep: CHUNK ∈ {1, 2, 16} with 1000 random operands -> S/Cout/Ofl match a reference model; done latency is NCH cycles after accept.

Source files
------------

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: multi-cycle add/subtract unit.
// It adds CHUNK bits of the operands on each clock, least significant chunk
// first, and keeps the carry in a register between chunks. When the last
// chunk is done it raises a one-cycle done pulse together with the sum, the
// carry-out and the signed overflow flag.
module serial_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ofl
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [CW-1:0]     cnt_reg;
    logic              carry_reg;
    logic [WIDTH-1:0]  opa_reg;
    logic [WIDTH-1:0]  opb_reg;
    logic              cout_reg;
    logic              ofl_reg;

    logic [CHUNK-1:0]  a_chunk     [NCH];
    logic [CHUNK-1:0]  b_chunk     [NCH];
    logic [CHUNK-1:0]  s_chunk_reg [NCH];

    logic              accept;
    logic              step;
    logic              last;
    logic [CHUNK-1:0]  a_sel;
    logic [CHUNK-1:0]  b_sel;
    logic [CHUNK:0]    chunk_sum;
    logic              msb_cin;

    assign accept = (state_reg == IDLE) && start;
    assign step   = (state_reg == RUN);
    assign last   = (cnt_reg == LAST);

    // Slice the latched operands into chunks and reassemble S from the
    // per-chunk result registers.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
            assign a_chunk[gi] = opa_reg[gi*CHUNK +: CHUNK];
            assign b_chunk[gi] = opb_reg[gi*CHUNK +: CHUNK];
            assign S[gi*CHUNK +: CHUNK] = s_chunk_reg[gi];

            // Result chunk: cleared on accept, written when the counter points at it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_chunk_reg[gi] <= '0;
                end else if (accept) begin
                    s_chunk_reg[gi] <= '0;
                end else if (step && (cnt_reg == CW'(gi))) begin
                    s_chunk_reg[gi] <= chunk_sum[CHUNK-1:0];
                end
            end
        end
    endgenerate

    // One chunk-wide adder shared by every RUN cycle.
    always_comb begin
        a_sel     = a_chunk[cnt_reg];
        b_sel     = b_chunk[cnt_reg];
        chunk_sum = {1'b0, a_sel} + {1'b0, b_sel} + {{CHUNK{1'b0}}, carry_reg};
        // The carry into the top bit of the chunk is recovered from that bit's
        // sum and operands; on the last chunk this is the carry into bit WIDTH-1.
        msb_cin   = chunk_sum[CHUNK-1] ^ a_sel[CHUNK-1] ^ b_sel[CHUNK-1];
    end

    // Operand latch, chunk counter, running carry and final flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_reg   <= '0;
            opb_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ofl_reg   <= 1'b0;
        end else if (accept) begin
            opa_reg   <= A;
            opb_reg   <= sub ? ~B : B;
            carry_reg <= sub ? 1'b1 : Cin;
            cnt_reg   <= '0;
        end else if (step) begin
            carry_reg <= chunk_sum[CHUNK];
            if (last) begin
                cout_reg <= chunk_sum[CHUNK];
                ofl_reg  <= msb_cin ^ chunk_sum[CHUNK];
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: start is only honoured in IDLE, DONE always returns to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (state_reg != IDLE);
        done = (state_reg == DONE);
    end

    assign Cout = cout_reg;
    assign Ofl  = ofl_reg;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Testbench for serial_chunk_adder: directed vector table and multi-cycle
// sequences on a CHUNK=4 instance, plus random operands on CHUNK=1, 2 and 16
// instances checked against an arithmetic reference model.
module tb_serial_chunk_adder;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ofl;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        cout;
        logic        ofl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_n_sw;
    logic        start, sub, cin;
    logic [15:0] a, b;
    logic        busy, done, cout, ofl;
    logic [15:0] s;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .A     (a),
        .B     (b),
        .Cin   (cin),
        .busy  (busy),
        .done  (done),
        .S     (s),
        .Cout  (cout),
        .Ofl   (ofl)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic res_t model(input logic [15:0] ia, input logic [15:0] ib,
                                   input logic icin, input logic isub);
        res_t r;
        int ua, ub, sa, sb, full, sres;
        ua = int'(ia);
        ub = int'(ib);
        sa = int'($signed(ia));
        sb = int'($signed(ib));
        if (isub) begin
            full   = ua - ub;
            sres   = sa - sb;
            r.cout = (ua >= ub);
        end else begin
            full   = ua + ub + int'(icin);
            sres   = sa + sb + int'(icin);
            r.cout = (full > 65535);
        end
        r.s   = 16'(full);
        r.ofl = (sres > 32767) || (sres < -32768);
        return r;
    endfunction

    // One operation on the CHUNK=4 instance; lat = cycles from accept edge to done.
    task automatic op4(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                       input logic isub, output logic [15:0] rs, output logic rc,
                       output logic ro, output int lat, output int bcnt, output logic dn_after);
        @(negedge clk);
        a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; bcnt = 0; rs = '0; rc = 1'b0; ro = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = i; rs = s; rc = cout; ro = ofl;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (busy) bcnt++;
        dn_after = done;
    endtask

    // Random sweep instances with other chunk sizes.
    for (genvar gi = 0; gi < 3; gi++) begin : g_sw
        localparam int CH  = (gi == 0) ? 1 : ((gi == 1) ? 2 : 16);
        localparam int NCS = 16 / CH;
        logic        st, sb, ci, bz, dn, co, of;
        logic [15:0] aa, bb, ss;
        logic        fin;

        serial_chunk_adder #(.WIDTH(16), .CHUNK(CH)) u_sw (
            .clk   (clk),
            .rst_n (rst_n_sw),
            .start (st),
            .sub   (sb),
            .A     (aa),
            .B     (bb),
            .Cin   (ci),
            .busy  (bz),
            .done  (dn),
            .S     (ss),
            .Cout  (co),
            .Ofl   (of)
        );

        initial begin
            res_t e;
            int   lat;
            st = 1'b0; sb = 1'b0; ci = 1'b0; aa = '0; bb = '0; fin = 1'b0;
            wait (rst_n_sw === 1'b1);
            for (int n = 0; n < 1000; n++) begin
                @(negedge clk);
                aa = 16'($urandom); bb = 16'($urandom);
                ci = 1'($urandom);  sb = 1'($urandom);
                st = 1'b1;
                e = model(aa, bb, ci, sb);
                @(posedge clk); #1;
                st = 1'b0;
                lat = -1;
                for (int i = 0; i < NCS + 8; i++) begin
                    if (dn) begin
                        lat = i;
                        break;
                    end
                    @(posedge clk); #1;
                end
                chk($sformatf("sw%0d_lat a=%h b=%h", CH, aa, bb), 32'(lat), 32'(NCS));
                chk($sformatf("sw%0d_s a=%h b=%h sub=%b cin=%b", CH, aa, bb, sb, ci), 32'(ss), 32'(e.s));
                chk($sformatf("sw%0d_cout a=%h b=%h sub=%b", CH, aa, bb, sb), 32'(co), 32'(e.cout));
                chk($sformatf("sw%0d_ofl a=%h b=%h sub=%b", CH, aa, bb, sb), 32'(of), 32'(e.ofl));
                @(posedge clk);
            end
            fin = 1'b1;
        end
    end

    initial begin
        vec_t        vt [6];
        logic [15:0] rs;
        logic        rc, ro, dn_after, got;
        int          lat, bcnt, n;
        int          tp [3];

        vt[0] = '{16'h1234, 16'h0FF1, 1'b0, 1'b0, 16'h2225, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
        vt[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

        rst_n = 1'b0; rst_n_sw = 1'b0;
        start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;

        // Reset state, observed before any clock edge.
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_s",    32'(s),    32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ofl",  32'(ofl),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; rst_n_sw = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 6; i++) begin
            op4(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, rs, rc, ro, lat, bcnt, dn_after);
            $display("vec %0d: a=%h b=%h cin=%b sub=%b -> s=%h cout=%b ofl=%b lat=%0d",
                     i, vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, rs, rc, ro, lat);
            chk($sformatf("vec%0d_s", i),    32'(rs),   32'(vt[i].s));
            chk($sformatf("vec%0d_cout", i), 32'(rc),   32'(vt[i].cout));
            chk($sformatf("vec%0d_ofl", i),  32'(ro),   32'(vt[i].ofl));
            chk($sformatf("vec%0d_lat", i),  32'(lat),  32'd4);
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd5);
            chk($sformatf("vec%0d_done_width", i),  32'(dn_after), 32'd0);
            chk($sformatf("vec%0d_s_hold", i),      32'(s), 32'(vt[i].s));
        end

        // start re-asserted during RUN and DONE with other operands: ignored.
        @(negedge clk);
        a = 16'h1234; b = 16'h0FF1; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 16'hAAAA; b = 16'hAAAA; cin = 1'b1; sub = 1'b1;
        lat = -1; rs = '0; rc = 1'b0; ro = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                lat = i; rs = s; rc = cout; ro = ofl;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        got = busy;
        start = 1'b0;
        $display("busy_ignore: s=%h cout=%b ofl=%b lat=%0d busy_after=%b", rs, rc, ro, lat, got);
        chk("ign_lat",  32'(lat), 32'd4);
        chk("ign_s",    32'(rs),  32'h2225);
        chk("ign_cout", 32'(rc),  32'd0);
        chk("ign_ofl",  32'(ro),  32'd0);
        chk("ign_busy_after_done", 32'(got), 32'd0);
        @(posedge clk); #1;
        chk("ign_idle_busy", 32'(busy), 32'd0);
        chk("ign_s_hold",    32'(s),    32'h2225);

        // start held high: back-to-back operations every NCH+2 cycles.
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
        n = 0; tp[0] = 0; tp[1] = 0; tp[2] = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(posedge clk); #1;
            if (done) begin
                tp[n] = cyc;
                n++;
            end
        end
        start = 1'b0;
        $display("held_start: pulses=%0d at %0d %0d %0d", n, tp[0], tp[1], tp[2]);
        chk("held_pulses", 32'(n), 32'd3);
        chk("held_gap1",   32'(tp[1] - tp[0]), 32'd6);
        chk("held_gap2",   32'(tp[2] - tp[1]), 32'd6);
        chk("held_s",      32'(s), 32'h0002);
        @(posedge clk); #1;

        // Asynchronous reset in the second RUN cycle.
        op4(16'h8000, 16'h0001, 1'b0, 1'b1, rs, rc, ro, lat, bcnt, dn_after);
        chk("pre_rst_flags", 32'({rc, ro}), 32'b11);
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async_reset: busy=%b done=%b s=%h cout=%b ofl=%b", busy, done, s, cout, ofl);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_s",    32'(s),    32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        chk("arst_ofl",  32'(ofl),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op4(16'h0001, 16'h0002, 1'b0, 1'b0, rs, rc, ro, lat, bcnt, dn_after);
        $display("post_reset: s=%h cout=%b ofl=%b lat=%0d", rs, rc, ro, lat);
        chk("post_rst_s",   32'(rs),  32'h0003);
        chk("post_rst_lat", 32'(lat), 32'd4);
        chk("post_rst_flags", 32'({rc, ro}), 32'b00);

        // Wait for the random sweeps, bounded.
        for (int i = 0; i < 40000; i++) begin
            if (g_sw[0].fin && g_sw[1].fin && g_sw[2].fin) break;
            @(posedge clk);
        end
        chk("sweep_finished", 32'({g_sw[0].fin, g_sw[1].fin, g_sw[2].fin}), 32'b111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
